// File: rtl/fixed_round_pipe_if.sv
// Valid/ready stream bundle for the fixed-point rounding pipe.
// The slave modport faces the rounding unit.
interface fixed_round_pipe_if #(
    parameter int W = 7
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_oflag;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_oflag
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_oflag
    );
endinterface

// File: rtl/fixed_round_pipe.sv
// Two-stage streaming rounding unit for signed WI.WF fixed-point data.
// Modes: floor, ceil, trunc, half-up, half-even; 5-7 act as floor.
module fixed_round_pipe #(
    parameter int WI  = 3,
    parameter int WF  = 4,
    parameter int SAT = 1,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fixed_round_pipe_if.slave io,
    input  logic          clr_cnt,
    output logic [CW-1:0] ovf_cnt
);
    localparam int W = WI + WF;
    localparam logic [WF-1:0] HALF = WF'(1) << (WF - 1);
    localparam logic [WI-1:0] IMAX = {1'b0, {(WI-1){1'b1}}};

    logic          en;
    logic [WF-1:0] frac;
    logic          bump_d;

    logic          v1_q;
    logic [WI-1:0] ip1_q;
    logic          bump1_q;

    logic          v2_q;
    logic [W-1:0]  data2_q;
    logic          of2_q;
    logic [CW-1:0] cnt_q;

    logic [WI-1:0] ip_sum;
    logic          ovf_d;
    logic [W-1:0]  data_d;

    assign en          = ~v2_q | io.out_ready;
    assign io.in_ready = en;
    assign frac        = io.in_data[WF-1:0];

    always_comb begin
        bump_d = 1'b0;
        case (io.in_mode)
            3'd1:    bump_d = |frac;
            3'd2:    bump_d = io.in_data[W-1] & (|frac);
            3'd3:    bump_d = (frac >= HALF);
            3'd4:    bump_d = (frac > HALF) |
                              ((frac == HALF) & io.in_data[WF]);
            default: bump_d = 1'b0;
        endcase
    end

    // Only the integer field carries information past S1.
    always_comb begin
        ip_sum = ip1_q + WI'(bump1_q);
        ovf_d  = bump1_q & (ip1_q == IMAX);
        data_d = {ip_sum, {WF{1'b0}}};
        if (ovf_d && SAT != 0) data_d = {IMAX, {WF{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            ip1_q   <= '0;
            bump1_q <= 1'b0;
            v2_q    <= 1'b0;
            data2_q <= '0;
            of2_q   <= 1'b0;
        end else if (en) begin
            v1_q <= io.in_valid;
            if (io.in_valid) begin
                ip1_q   <= io.in_data[W-1:WF];
                bump1_q <= bump_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                data2_q <= data_d;
                of2_q   <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (v2_q && io.out_ready && of2_q
                     && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign io.out_valid = v2_q;
    assign io.out_data  = data2_q;
    assign io.out_oflag = of2_q;
    assign ovf_cnt      = cnt_q;
endmodule

// File: tb/tb_fixed_round_pipe.sv
// Scoreboard bench: a saturating (CW=2) and a wrapping (CW=8) unit
// share one stimulus stream and are checked against an integer model.
module tb_fixed_round_pipe;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       out_ready = 1;
    logic       clr_cnt = 0;
    logic [6:0] in_data = 0;
    logic [2:0] in_mode = 0;
    logic [1:0] cnt_s;
    logic [7:0] cnt_w;

    always #5 clk = ~clk;

    fixed_round_pipe_if #(.W(7)) if_s ();
    fixed_round_pipe_if #(.W(7)) if_w ();

    assign if_s.in_valid  = in_valid;
    assign if_s.in_data   = in_data;
    assign if_s.in_mode   = in_mode;
    assign if_s.out_ready = out_ready;
    assign if_w.in_valid  = in_valid;
    assign if_w.in_data   = in_data;
    assign if_w.in_mode   = in_mode;
    assign if_w.out_ready = out_ready;

    fixed_round_pipe #(.WI(3), .WF(4), .SAT(1), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .io(if_s.slave),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_s)
    );

    fixed_round_pipe #(.WI(3), .WF(4), .SAT(0), .CW(8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .io(if_w.slave),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_w)
    );

    typedef struct {
        logic [6:0] ds;
        logic [6:0] dw;
        logic       of;
        int         hc;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_cs = 0;
    int   m_cw = 0;
    bit   lat_en = 0;
    bit   prev_stall = 0;
    logic [6:0] prev_d;
    logic       prev_of;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Round to an integer value with plain integer arithmetic.
    function automatic exp_t model(input logic [6:0] d,
                                   input logic [2:0] m);
        exp_t e;
        int x, f, n, r;
        x = $signed(d);
        f = x & 15;
        n = (x - f) / 16;
        case (m)
            3'd1: r = n + ((f != 0) ? 1 : 0);
            3'd2: r = (x < 0 && f != 0) ? n + 1 : n;
            3'd3: r = n + ((f >= 8) ? 1 : 0);
            3'd4: r = (f > 8) ? n + 1 :
                      (f == 8) ? n + (n & 1) : n;
            default: r = n;
        endcase
        e.of  = (r > 3);
        e.dw  = 7'((r * 16) & 127);
        e.ds  = e.of ? 7'h30 : e.dw;
        e.hc  = 0;
        e.lat = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        logic ofl;
        hs  = 0;
        ofl = 0;
        if (rst_n) begin
            chk("ovf_cnt_sat", 32'(cnt_s), 32'(m_cs));
            chk("ovf_cnt_wrap", 32'(cnt_w), 32'(m_cw));
            if (prev_stall) begin
                chk("stall_valid", 32'(if_s.out_valid), 1);
                chk("stall_data", 32'(if_s.out_data), 32'(prev_d));
                chk("stall_oflag", 32'(if_s.out_oflag), 32'(prev_of));
            end
            if (if_s.out_valid && !out_ready)
                chk("stall_in_ready", 32'(if_s.in_ready), 0);
            if (!if_s.out_valid)
                chk("idle_in_ready", 32'(if_s.in_ready), 1);
            if (in_valid && if_s.in_ready) begin
                e = model(in_data, in_mode);
                e.hc  = cyc + 1;
                e.lat = lat_en;
                q.push_back(e);
            end
            if (if_s.out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h required none",
                             if_s.out_data);
                end else begin
                    e = q.pop_front();
                    chk("data_sat", 32'(if_s.out_data), 32'(e.ds));
                    chk("data_wrap", 32'(if_w.out_data), 32'(e.dw));
                    chk("oflag_sat", 32'(if_s.out_oflag), 32'(e.of));
                    chk("oflag_wrap", 32'(if_w.out_oflag), 32'(e.of));
                    if (e.lat) chk("latency", 32'(cyc + 1 - e.hc), 2);
                    hs  = 1;
                    ofl = e.of;
                end
            end
            if (clr_cnt) begin
                m_cs = 0;
                m_cw = 0;
            end else if (hs && ofl) begin
                m_cs = (m_cs < 3) ? m_cs + 1 : 3;
                m_cw = (m_cw < 255) ? m_cw + 1 : 255;
            end
            prev_stall = if_s.out_valid && !out_ready;
            prev_d     = if_s.out_data;
            prev_of    = if_s.out_oflag;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic send(input logic [6:0] d, input logic [2:0] m);
        bit hs;
        int n;
        hs = 0;
        n  = 0;
        in_valid = 1;
        in_data  = d;
        in_mode  = m;
        do begin
            @(negedge clk);
            hs = if_s.in_ready;
            @(posedge clk);
            n++;
        end while (!hs && n < 100);
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
        end
        #1;
        in_valid = 0;
        in_data  = 7'($urandom);
        in_mode  = 3'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0",
                     q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        q.delete();
        m_cs = 0;
        m_cw = 0;
        #1;
        chk("rst_valid_sat", 32'(if_s.out_valid), 0);
        chk("rst_valid_wrap", 32'(if_w.out_valid), 0);
        chk("rst_data", 32'(if_s.out_data), 0);
        chk("rst_oflag", 32'(if_s.out_oflag), 0);
        chk("rst_cnt_sat", 32'(cnt_s), 0);
        chk("rst_cnt_wrap", 32'(cnt_w), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("rst_in_ready", 32'(if_s.in_ready), 1);
    endtask

    logic [6:0] dv[];
    logic [2:0] mv[];

    initial begin
        dv = '{7'h08, 7'h78, 7'h40, 7'h78, 7'h61, 7'h78, 7'h17,
               7'h08, 7'h18, 7'h28, 7'h78, 7'h2D, 7'h3D, 7'h3C,
               7'h3D, 7'h3D, 7'h3D, 7'h40, 7'h40, 7'h40, 7'h40};
        mv = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd3, 3'd3,
               3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd3,
               3'd5, 3'd6, 3'd7, 3'd0, 3'd2, 3'd3, 3'd4};
        @(posedge clk);
        #1;
        do_reset();

        lat_en = 1;
        foreach (dv[i]) send(dv[i], mv[i]);
        drain();
        chk("cnt_two_sat", 32'(cnt_s), 2);

        send(7'h3D, 3'd1);
        send(7'h3C, 3'd4);
        drain();
        chk("cnt_hold_sat", 32'(cnt_s), 3);
        chk("cnt_four_wrap", 32'(cnt_w), 4);

        lat_en = 0;
        send(7'h3F, 3'd3);
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1;
        clr_cnt   = 1;
        @(posedge clk);
        #1;
        clr_cnt = 0;
        #1;
        chk("clr_wins_sat", 32'(cnt_s), 0);
        chk("clr_wins_wrap", 32'(cnt_w), 0);
        drain();

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(7'($urandom), 3'($urandom_range(0, 7)));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();

        fork
            begin
                for (int i = 0; i < 30; i++)
                    send(7'($urandom), 3'($urandom_range(0, 4)));
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        drain();

        send(7'h3D, 3'd1);
        send(7'h18, 3'd4);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        lat_en = 1;
        send(7'h29, 3'd3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fixed_round_pipe.md
# fixed_round_pipe

Pipelined, mode-selectable rounding unit for signed two's-complement WI.WF fixed-point data. Each sample is rounded to an integer value in the same WI.WF format, with fractional bits cleared. Five rounding modes are supported, along with an overflow flag, optional saturation, and a saturating overflow event counter. It sits on valid/ready streams between the team's fixed-point arithmetic blocks and generalises the combinational ceil function into a streaming, multi-mode, back-pressurable stage.

## Interface
- WI, default 3: integer bits including sign; WI >= 2.
- WF, default 4: fractional bits; WF >= 1.
- SAT, default 1: 1 = saturate on overflow, 0 = wrap on overflow.
- CW, default 8: overflow counter width.
- clk  input  1  clock; all logic runs on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  WI+WF  signed fixed-point input.
- in_mode  input  3  rounding mode, captured with the sample.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WI+WF  rounded result; fractional bits are always 0.
- out_oflag  output  1  the true rounded value is not representable in WI.WF.
- ovf_cnt  output  CW  count of output handshakes with out_oflag=1; saturates at all-ones.
- clr_cnt  input  1  synchronous clear of ovf_cnt.

## Operation
- Definitions:
  - frac = x[WF-1:0].
  - half = 1 followed by WF-1 zeros.
  - base = x with frac forced to 0, i.e. floor(x).
  - one = 1<<WF.
- Modes (bump is 1 when one is added to base):
  - 0 FLOOR: no bump.
  - 1 CEIL: bump if frac != 0.
  - 2 TRUNC (toward zero): same as FLOOR if the sign is 0, same as CEIL if the sign is 1.
  - 3 HALF_UP (floor(x+0.5)): bump if frac >= half.
  - 4 HALF_EVEN: bump if frac > half; if frac == half, bump only when x[WF] = 1 (odd integer part).
  - 5-7 reserved: behave as FLOOR; out_oflag = 0.
- Arithmetic: base + one is computed in WI+WF+1 bits.
  - Overflow occurs only when bump = 1 and base = maximum positive integer (0 followed by all-ones integer bits).
  - FLOOR never overflows. The most negative input never overflows.
- On overflow:
  - SAT=1: out_data = maximum positive integer (e.g. 011_0000 for 3.4).
  - SAT=0: out_data = the wrapped sum (e.g. 100_0000).
  - out_oflag = 1 in both cases.
- Stage S1 registers in_data, in_mode and the bump decision.
- Stage S2 registers the sum, saturation result and out_oflag.
- ovf_cnt:
  - Increments by 1 on each output handshake (out_valid & out_ready) where out_oflag = 1.
  - Holds once it reaches 2^CW-1.
  - clr_cnt forces it to 0 and wins over a simultaneous increment.

## Timing
- Reset (rst_n low, asynchronous):
  - Both stage valids = 0, out_valid = 0, out_data = 0, out_oflag = 0, ovf_cnt = 0.
  - in_ready = 1 combinationally, as soon as rst_n is high.
- Global advance: en = ~out_valid | out_ready, and in_ready = en.
  - Input handshake: in_valid & in_ready. S1 and S2 load only when en = 1.
- Latency and throughput:
  - A sample accepted at edge N presents out_valid at edge N+2 if out_ready stayed high.
  - Throughput is 1 sample/cycle; there are no bubbles while out_ready = 1.
- Stall (out_valid & ~out_ready):
  - out_data, out_oflag and out_valid hold stable.
  - in_ready = 0; no sample is lost, duplicated or reordered.
- An S1 bubble (in_valid = 0 while en = 1) propagates as out_valid = 0 two cycles later.
- Reset asserted mid-stream: all in-flight samples are discarded immediately; no output appears after reset release until new inputs arrive.
- in_mode is sampled only at the input handshake; changing it later does not affect in-flight samples.

## Test plan
- CEIL with out_ready=1: 000_1000 (0.5) -> 001_0000, oflag=0, two cycles later. 111_1000 (-0.5) -> 000_0000. 100_0000 (-4.0) -> 100_0000, oflag=0.
- FLOOR/TRUNC/HALF_UP:
  - FLOOR 111_1000 -> 111_0000 (-1.0).
  - TRUNC 110_0001 (-1.9375) -> 111_0000.
  - HALF_UP 111_1000 -> 000_0000.
  - HALF_UP 001_0111 -> 001_0000.
- HALF_EVEN: 000_1000 -> 000_0000. 001_1000 (1.5) -> 010_0000. 010_1000 (2.5) -> 010_0000. 111_1000 -> 000_0000. 010_1101 -> 011_0000.
- Overflow: CEIL 011_1101 (3.8125), and HALF_UP 011_1100.
  - SAT=1: 011_0000 with oflag=1.
  - SAT=0: 100_0000 with oflag=1.
  - ovf_cnt increments only at the output handshake. With CW=2 it stops at 3; clr_cnt together with an overflow handshake gives 0.
- Backpressure: stream 6 random samples and modes with out_ready low for 5 cycles mid-stream.
  - in_ready drops while out_valid & ~out_ready.
  - Outputs are in order, complete, and match a reference model.
  - out_data stays stable while stalled.
- Reset: pulse rst_n low with 2 samples in flight -> out_valid=0 and ovf_cnt=0 immediately, no stale outputs after release, and the next sample has latency 2.
